// File: rtl/multdiv_ctrl_if.sv
// ----------------------------------------------------------------------------
// multdiv_ctrl_if
//   Bundles every non-clock/reset signal of the multiply/divide controller:
//     pipeline issue side : ctrl_MULT, ctrl_DIV, data_operandA/B, rd_in
//     unit side           : unit_operandA/B, unit_ctrl_MULT/DIV,
//                           mult_/div_result, mult_/div_exception,
//                           mult_/div_resultRDY
//     writeback side      : data_result, data_exception, data_resultRDY, rd_out
//     pipeline control    : stall
//   slave  : the controller itself.
//   master : the surrounding pipeline plus the arithmetic units (or a bench).
// ----------------------------------------------------------------------------
interface multdiv_ctrl_if;
    // issue from pipeline
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  rd_in;

    // to / from the arithmetic units
    logic [31:0] unit_operandA;
    logic [31:0] unit_operandB;
    logic        unit_ctrl_MULT;
    logic        unit_ctrl_DIV;
    logic [31:0] mult_result;
    logic [31:0] div_result;
    logic        mult_exception;
    logic        div_exception;
    logic        mult_resultRDY;
    logic        div_resultRDY;

    // back to pipeline
    logic        stall;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [4:0]  rd_out;

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, rd_in,
        input  mult_result, div_result, mult_exception, div_exception,
        input  mult_resultRDY, div_resultRDY,
        output unit_operandA, unit_operandB, unit_ctrl_MULT, unit_ctrl_DIV,
        output stall, data_result, data_exception, data_resultRDY, rd_out
    );

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, rd_in,
        output mult_result, div_result, mult_exception, div_exception,
        output mult_resultRDY, div_resultRDY,
        input  unit_operandA, unit_operandB, unit_ctrl_MULT, unit_ctrl_DIV,
        input  stall, data_result, data_exception, data_resultRDY, rd_out
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// ----------------------------------------------------------------------------
// multdiv_ctrl
//   Sequences a single multiply or divide operation between the pipeline and
//   the external multi-cycle mult/div units.
//
//   IDLE  : waits for an issue pulse (ctrl_MULT / ctrl_DIV).
//   START : one cycle; pulses the selected unit's start line.
//   WAIT  : waits for the selected unit's resultRDY, or aborts after TIMEOUT
//           cycles with data_exception = 1 and data_result = 0.
//   DONE  : one cycle; data_resultRDY = 1 with result, exception and rd_out.
//           A new issue seen here goes straight to START.
//
//   Ports
//     clock  : rising-edge clock
//     reset  : synchronous, active-high; returns to IDLE and clears outputs
//     bus    : multdiv_ctrl_if.slave (issue, unit and writeback signals)
//
//   Parameter
//     TIMEOUT : WAIT cycles allowed before abort (1..63, 6-bit counter)
// ----------------------------------------------------------------------------
module multdiv_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic           clock,
    input  logic           reset,
    multdiv_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [5:0] TIMEOUT_CNT = 6'(TIMEOUT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state_reg,   state_next;
    logic        op_mult_reg, op_mult_next;   // 1 = multiply, 0 = divide
    logic [31:0] opa_reg,     opa_next;
    logic [31:0] opb_reg,     opb_next;
    logic [4:0]  rd_reg,      rd_next;        // tag of the op in flight
    logic [5:0]  count_reg,   count_next;
    logic [31:0] result_reg,  result_next;
    logic        exc_reg,     exc_next;
    logic [4:0]  rd_out_reg,  rd_out_next;    // tag of the last reported op

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    logic        issue;
    logic        accept;
    logic        sel_rdy;
    logic        sel_exc;
    logic [31:0] sel_result;
    logic [5:0]  count_inc;
    logic        timeout_hit;

    assign issue  = bus.ctrl_MULT | bus.ctrl_DIV;

    // Issue is only honoured when no op is in flight.
    assign accept = issue && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    // Only the unit that was started is listened to; the other unit's
    // handshake is ignored even if it fires.
    assign sel_rdy    = op_mult_reg ? bus.mult_resultRDY : bus.div_resultRDY;
    assign sel_exc    = op_mult_reg ? bus.mult_exception : bus.div_exception;
    assign sel_result = op_mult_reg ? bus.mult_result    : bus.div_result;

    // The counter is 0 in the first WAIT cycle, so aborting when the
    // incremented value reaches TIMEOUT gives exactly TIMEOUT WAIT cycles.
    assign count_inc   = count_reg + 6'd1;
    assign timeout_hit = (count_inc == TIMEOUT_CNT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        op_mult_next = op_mult_reg;
        opa_next     = opa_reg;
        opb_next     = opb_reg;
        rd_next      = rd_reg;
        count_next   = count_reg;
        result_next  = result_reg;
        exc_next     = exc_reg;
        rd_out_next  = rd_out_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                state_next = accept ? ST_START : ST_IDLE;
            end

            ST_START: begin
                state_next = ST_WAIT;
                count_next = 6'd0;
            end

            ST_WAIT: begin
                count_next = count_inc;
                // RDY is tested first so a result arriving on the
                // timeout cycle is still delivered.
                if (sel_rdy) begin
                    result_next = sel_result;
                    exc_next    = sel_exc;
                    rd_out_next = rd_reg;
                    state_next  = ST_DONE;
                end else if (timeout_hit) begin
                    result_next = 32'd0;
                    exc_next    = 1'b1;
                    rd_out_next = rd_reg;
                    state_next  = ST_DONE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Latch the new op. MULT has priority when both pulses arrive.
        // rd_out is separate from rd_reg so a DONE-cycle issue does not
        // disturb the tag being reported in that same cycle.
        if (accept) begin
            op_mult_next = bus.ctrl_MULT;
            opa_next     = bus.data_operandA;
            opb_next     = bus.data_operandB;
            rd_next      = bus.rd_in;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            op_mult_reg <= 1'b0;
            opa_reg     <= 32'd0;
            opb_reg     <= 32'd0;
            rd_reg      <= 5'd0;
            count_reg   <= 6'd0;
            result_reg  <= 32'd0;
            exc_reg     <= 1'b0;
            rd_out_reg  <= 5'd0;
        end else begin
            state_reg   <= state_next;
            op_mult_reg <= op_mult_next;
            opa_reg     <= opa_next;
            opb_reg     <= opb_next;
            rd_reg      <= rd_next;
            count_reg   <= count_next;
            result_reg  <= result_next;
            exc_reg     <= exc_next;
            rd_out_reg  <= rd_out_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // ------------------------------------------------------------------
    assign bus.unit_operandA  = opa_reg;
    assign bus.unit_operandB  = opb_reg;
    assign bus.unit_ctrl_MULT = (state_reg == ST_START) &&  op_mult_reg;
    assign bus.unit_ctrl_DIV  = (state_reg == ST_START) && !op_mult_reg;
    assign bus.stall          = (state_reg == ST_START) || (state_reg == ST_WAIT);
    assign bus.data_resultRDY = (state_reg == ST_DONE);
    assign bus.data_result    = result_reg;
    assign bus.data_exception = exc_reg;
    assign bus.rd_out         = rd_out_reg;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multdiv_ctrl
//   Directed scenarios plus a randomized run for multdiv_ctrl. The bench plays
//   both the pipeline and the two arithmetic units; expected writebacks are
//   computed from the issued operands with plain arithmetic.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multdiv_ctrl;

    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    multdiv_ctrl_if bus();

    multdiv_ctrl #(.TIMEOUT(40)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.ctrl_MULT      = 1'b0;
        bus.ctrl_DIV       = 1'b0;
        bus.data_operandA  = 32'd0;
        bus.data_operandB  = 32'd0;
        bus.rd_in          = 5'd0;
        bus.mult_result    = 32'd0;
        bus.div_result     = 32'd0;
        bus.mult_exception = 1'b0;
        bus.div_exception  = 1'b0;
        bus.mult_resultRDY = 1'b0;
        bus.div_resultRDY  = 1'b0;
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.rd_in         = rd;
    endtask

    // What an ideal unit returns: {exception, result}
    function automatic logic [32:0] unit_answer(input logic is_mult,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        if (is_mult) return {1'b0, a * b};
        if (b == 32'd0) return {1'b1, 32'd0};
        return {1'b0, 32'($signed(a) / $signed(b))};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) tick();
        issue(1'b1, 1'b0, 32'd11, 32'd22, 5'd9);   // issue during reset
        tick();
        reset = 1'b0;
        idle_inputs();
        total++; if ({bus.stall, bus.unit_ctrl_MULT, bus.unit_ctrl_DIV, bus.data_resultRDY, bus.data_exception} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {bus.stall, bus.unit_ctrl_MULT, bus.unit_ctrl_DIV, bus.data_resultRDY, bus.data_exception}); end
        total++; if (bus.data_result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", bus.data_result); end
        total++; if (bus.rd_out !== 5'd0) begin bad++; $display("FAIL reset_rd_out: got %0d want 0", bus.rd_out); end
        total++; if ({bus.unit_operandA, bus.unit_operandB} !== 64'd0) begin bad++; $display("FAIL reset_operands: got %h want 0", {bus.unit_operandA, bus.unit_operandB}); end
        tick();
        total++; if ({bus.stall, bus.unit_ctrl_MULT, bus.unit_operandA} !== 34'd0) begin
            bad++; $display("FAIL reset_issue_ignored: stall=%b ctrl=%b opA=%h want all 0", bus.stall, bus.unit_ctrl_MULT, bus.unit_operandA); end
    endtask

    task automatic test_mult();
        logic [32:0] ans;
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        tick(); idle_inputs();                         // START
        total++; if ({bus.unit_ctrl_MULT, bus.unit_ctrl_DIV, bus.stall} !== 3'b101) begin
            bad++; $display("FAIL mult_start: mult/div/stall got %b want 101", {bus.unit_ctrl_MULT, bus.unit_ctrl_DIV, bus.stall}); end
        total++; if ({bus.unit_operandA, bus.unit_operandB} !== {32'd7, 32'hFFFF_FFFD}) begin
            bad++; $display("FAIL mult_operands: got %h %h want 7 fffffffd", bus.unit_operandA, bus.unit_operandB); end
        for (int i = 1; i <= 3; i++) begin
            tick();                                     // WAIT i
            total++; if ({bus.unit_ctrl_MULT, bus.unit_ctrl_DIV, bus.stall, bus.data_resultRDY} !== 4'b0010) begin
                bad++; $display("FAIL mult_wait%0d: got %b want 0010", i, {bus.unit_ctrl_MULT, bus.unit_ctrl_DIV, bus.stall, bus.data_resultRDY}); end
            if (i == 3) begin
                ans = unit_answer(1'b1, bus.unit_operandA, bus.unit_operandB);
                bus.mult_result    = ans[31:0];
                bus.mult_exception = ans[32];
                bus.mult_resultRDY = 1'b1;
            end
        end
        tick(); idle_inputs();                         // DONE
        total++; if ({bus.data_resultRDY, bus.stall, bus.data_exception} !== 3'b100) begin
            bad++; $display("FAIL mult_done_flags: rdy/stall/exc got %b want 100", {bus.data_resultRDY, bus.stall, bus.data_exception}); end
        total++; if (bus.data_result !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_result: got %h want ffffffeb", bus.data_result); end
        total++; if (bus.rd_out !== 5'd5) begin bad++; $display("FAIL mult_rd_out: got %0d want 5", bus.rd_out); end
        total++; if (bus.unit_operandA !== 32'd7) begin bad++; $display("FAIL mult_opA_hold: got %h want 7", bus.unit_operandA); end
        tick();                                         // IDLE
        total++; if ({bus.data_resultRDY, bus.data_result, bus.rd_out} !== {1'b0, 32'hFFFF_FFEB, 5'd5}) begin
            bad++; $display("FAIL mult_after_done: rdy=%b res=%h rd=%0d want 0 ffffffeb 5", bus.data_resultRDY, bus.data_result, bus.rd_out); end
    endtask

    task automatic test_div_stray();
        logic [32:0] ans;
        issue(1'b0, 1'b1, 32'd100, 32'd7, 5'd12);
        tick(); idle_inputs();                         // START
        total++; if ({bus.unit_ctrl_MULT, bus.unit_ctrl_DIV} !== 2'b01) begin
            bad++; $display("FAIL div_start: mult/div got %b want 01", {bus.unit_ctrl_MULT, bus.unit_ctrl_DIV}); end
        tick();                                         // WAIT1: stray mult RDY
        bus.mult_resultRDY = 1'b1;
        bus.mult_result    = 32'hDEAD_BEEF;
        tick();                                         // WAIT2
        bus.mult_resultRDY = 1'b0;
        total++; if ({bus.stall, bus.data_resultRDY} !== 2'b10) begin
            bad++; $display("FAIL div_stray_ignored: stall/rdy got %b want 10", {bus.stall, bus.data_resultRDY}); end
        ans = unit_answer(1'b0, bus.unit_operandA, bus.unit_operandB);
        bus.div_result    = ans[31:0];
        bus.div_exception = ans[32];
        bus.div_resultRDY = 1'b1;
        tick(); idle_inputs();                         // DONE
        total++; if ({bus.data_resultRDY, bus.data_exception, bus.data_result, bus.rd_out} !== {1'b1, 1'b0, 32'd14, 5'd12}) begin
            bad++; $display("FAIL div_result: rdy=%b exc=%b res=%0d rd=%0d want 1 0 14 12", bus.data_resultRDY, bus.data_exception, bus.data_result, bus.rd_out); end
        tick();
    endtask

    task automatic test_dual_issue();
        issue(1'b1, 1'b1, 32'd3, 32'd4, 5'd3);
        tick(); idle_inputs();                         // START
        total++; if ({bus.unit_ctrl_MULT, bus.unit_ctrl_DIV} !== 2'b10) begin
            bad++; $display("FAIL dual_start: mult/div got %b want 10", {bus.unit_ctrl_MULT, bus.unit_ctrl_DIV}); end
        tick();                                         // WAIT1: both units answer
        bus.mult_result    = bus.unit_operandA * bus.unit_operandB;
        bus.mult_resultRDY = 1'b1;
        bus.div_result     = 32'd99;
        bus.div_exception  = 1'b1;
        bus.div_resultRDY  = 1'b1;
        tick(); idle_inputs();                         // DONE
        total++; if ({bus.data_resultRDY, bus.data_exception, bus.data_result} !== {1'b1, 1'b0, 32'd12}) begin
            bad++; $display("FAIL dual_result: rdy=%b exc=%b res=%0d want 1 0 12", bus.data_resultRDY, bus.data_exception, bus.data_result); end
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        issue(1'b1, 1'b0, 32'd5, 32'd6, 5'd7);
        tick(); idle_inputs();                         // START
        while (bus.data_resultRDY !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++; if (n != 41) begin bad++; $display("FAIL timeout_cycles: got %0d want 41", n); end
        total++; if ({bus.data_exception, bus.data_result, bus.rd_out} !== {1'b1, 32'd0, 5'd7}) begin
            bad++; $display("FAIL timeout_result: exc=%b res=%h rd=%0d want 1 0 7", bus.data_exception, bus.data_result, bus.rd_out); end
        tick();
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        issue(1'b0, 1'b1, 32'd50, 32'd5, 5'd20);
        tick(); idle_inputs();                         // START
        repeat (3) tick();                              // 3 cycles into WAIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if ({bus.stall, bus.data_resultRDY, bus.data_exception, bus.data_result, bus.rd_out, bus.unit_operandA} !== 72'd0) begin
            bad++; $display("FAIL midop_reset_outputs: stall=%b rdy=%b exc=%b res=%h rd=%0d opA=%h want all 0",
                bus.stall, bus.data_resultRDY, bus.data_exception, bus.data_result, bus.rd_out, bus.unit_operandA); end
        bus.div_result    = 32'd10;
        bus.div_resultRDY = 1'b1;
        tick(); idle_inputs();
        for (int i = 0; i < 5; i++) begin
            if (bus.data_resultRDY !== 1'b0 || bus.stall !== 1'b0) seen++;
            tick();
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midop_no_writeback: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [32:0] ans;
        issue(1'b1, 1'b0, 32'd9, 32'd9, 5'd1);
        tick(); idle_inputs();                         // START op1
        tick();                                         // WAIT1
        ans = unit_answer(1'b1, bus.unit_operandA, bus.unit_operandB);
        bus.mult_result    = ans[31:0];
        bus.mult_resultRDY = 1'b1;
        tick(); idle_inputs();                         // DONE op1
        total++; if ({bus.data_resultRDY, bus.data_result, bus.rd_out} !== {1'b1, 32'd81, 5'd1}) begin
            bad++; $display("FAIL b2b_first: rdy=%b res=%0d rd=%0d want 1 81 1", bus.data_resultRDY, bus.data_result, bus.rd_out); end
        issue(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd1000, 5'd2);
        tick(); idle_inputs();                         // START op2, no IDLE gap
        total++; if ({bus.stall, bus.unit_ctrl_MULT, bus.data_resultRDY, bus.unit_operandA} !== {3'b110, 32'hFFFF_FFFE}) begin
            bad++; $display("FAIL b2b_start: stall=%b mult=%b rdy=%b opA=%h want 1 1 0 fffffffe",
                bus.stall, bus.unit_ctrl_MULT, bus.data_resultRDY, bus.unit_operandA); end
        total++; if (bus.rd_out !== 5'd1) begin bad++; $display("FAIL b2b_rd_hold: got %0d want 1", bus.rd_out); end
        tick();                                         // WAIT1: issue must be ignored
        issue(1'b0, 1'b1, 32'd777, 32'd3, 5'd30);
        tick(); idle_inputs();                         // WAIT2
        total++; if ({bus.unit_ctrl_MULT, bus.unit_ctrl_DIV, bus.stall, bus.unit_operandA, bus.unit_operandB} !== {3'b001, 32'hFFFF_FFFE, 32'd1000}) begin
            bad++; $display("FAIL b2b_ignored_issue: ctrl=%b stall=%b opA=%h opB=%h want 00 1 fffffffe 3e8",
                {bus.unit_ctrl_MULT, bus.unit_ctrl_DIV}, bus.stall, bus.unit_operandA, bus.unit_operandB); end
        ans = unit_answer(1'b1, bus.unit_operandA, bus.unit_operandB);
        bus.mult_result    = ans[31:0];
        bus.mult_resultRDY = 1'b1;
        tick(); idle_inputs();                         // DONE op2
        total++; if ({bus.data_resultRDY, bus.data_result, bus.rd_out} !== {1'b1, 32'hFFFF_F830, 5'd2}) begin
            bad++; $display("FAIL b2b_second: rdy=%b res=%h rd=%0d want 1 fffff830 2", bus.data_resultRDY, bus.data_result, bus.rd_out); end
        tick();
    endtask

    task automatic test_random();
        logic        m, both, mult_sel, never;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic [32:0] exp_ans, ans;
        int          lat, stray_at, n, exp_n;
        for (int k = 0; k < 24; k++) begin
            m        = 1'($urandom_range(0, 1));
            both     = ($urandom_range(0, 5) == 0);
            mult_sel = m | both;
            a        = $urandom;
            if (a == 32'h8000_0000) a = 32'd1;
            b        = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            rd       = 5'($urandom);
            lat      = $urandom_range(1, 8);
            never    = ($urandom_range(0, 9) == 0);
            stray_at = $urandom_range(1, lat);
            exp_ans  = never ? {1'b1, 32'd0} : unit_answer(mult_sel, a, b);
            exp_n    = never ? 41 : lat + 1;

            issue(mult_sel, !m | both, a, b, rd);       // may land in a DONE cycle
            tick(); idle_inputs();                      // START
            total++; if ({bus.unit_ctrl_MULT, bus.unit_ctrl_DIV, bus.unit_operandA} !== {mult_sel, !mult_sel, a}) begin
                bad++; $display("FAIL rand%0d_start: mult=%b div=%b opA=%h want %b %b %h",
                    k, bus.unit_ctrl_MULT, bus.unit_ctrl_DIV, bus.unit_operandA, mult_sel, !mult_sel, a); end
            n = 0;
            while (bus.data_resultRDY !== 1'b1 && n < 100) begin
                tick(); idle_inputs();
                n++;
                if (n == stray_at) begin
                    if (mult_sel) begin bus.div_resultRDY = 1'b1;  bus.div_result  = $urandom; end
                    else          begin bus.mult_resultRDY = 1'b1; bus.mult_result = $urandom; end
                end
                if (!never && n == lat) begin
                    ans = unit_answer(mult_sel, bus.unit_operandA, bus.unit_operandB);
                    if (mult_sel) begin bus.mult_resultRDY = 1'b1; bus.mult_result = ans[31:0]; bus.mult_exception = ans[32]; end
                    else          begin bus.div_resultRDY  = 1'b1; bus.div_result  = ans[31:0]; bus.div_exception  = ans[32]; end
                end
            end
            idle_inputs();
            total++; if (n != exp_n) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", k, n, exp_n); end
            total++; if ({bus.data_exception, bus.data_result, bus.rd_out} !== {exp_ans, rd}) begin
                bad++; $display("FAIL rand%0d_writeback: exc=%b res=%h rd=%0d want %b %h %0d",
                    k, bus.data_exception, bus.data_result, bus.rd_out, exp_ans[32], exp_ans[31:0], rd); end
            if ($urandom_range(0, 1) == 1) tick();      // sometimes return to IDLE first
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_mult();
        test_div_stray();
        test_dual_issue();
        test_timeout();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 40, max WAIT cycles before abort (6-bit counter).
REQ-002 clock  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ctrl_MULT / ctrl_DIV  input  1 each  one-cycle issue pulses from pipeline.
REQ-005 data_operandA / data_operandB  input  32 each  operands valid with issue pulse.
REQ-006 rd_in  input  5  destination register tag valid with issue pulse.
REQ-007 unit_operandA / unit_operandB  output  32 each  latched operands to mult and div units.
REQ-008 unit_ctrl_MULT / unit_ctrl_DIV  output  1 each  start pulses to mult / div unit.
REQ-009 mult_result, div_result  input  32 each; mult_exception, div_exception, mult_resultRDY, div_resultRDY  input  1 each.
REQ-010 stall  output  1  freezes pipeline while an op is in flight.
REQ-011 data_result  output  32; data_exception, data_resultRDY  output  1; rd_out  output  5  writeback bundle.

Function
REQ-012 States SHALL be IDLE, START, WAIT, DONE, registered on clock.
REQ-013 Issue SHALL be accepted only in IDLE or DONE; on acceptance, operands, rd_in and op type (MULT/DIV) latched, next state START.
REQ-014 ctrl_MULT and ctrl_DIV high same cycle: MULT accepted, DIV dropped, no error flagged.
REQ-015 Issue pulses in START or WAIT SHALL be ignored; latched state unchanged.
REQ-016 START: exactly one cycle; selected unit_ctrl_* = 1, other = 0; unit_operandA/B = latched values; next state WAIT, counter cleared to 0.
REQ-017 unit_operandA/B SHALL hold latched values stable from START through DONE.
REQ-018 WAIT: counter +1 per cycle; only selected unit's resultRDY observed; non-selected RDY ignored.
REQ-019 Selected RDY high in WAIT: result and exception of selected unit registered; next state DONE.
REQ-020 Counter reaching TIMEOUT with no RDY: data_result = 0, data_exception = 1 registered; next state DONE.
REQ-021 RDY and timeout same cycle: RDY wins.
REQ-022 DONE: one cycle; data_resultRDY = 1, data_result/data_exception/rd_out valid; next state IDLE, or START if issue accepted that cycle.
REQ-023 data_resultRDY SHALL be 0 outside DONE; data_result, data_exception, rd_out hold last values.
REQ-024 stall = 1 in START and WAIT, else 0 (combinational on state).
REQ-025 Issue-to-data_resultRDY latency = unit latency + 2 cycles (START + DONE).

Reset
REQ-026 reset SHALL force IDLE, counter 0, all outputs 0 on next edge, regardless of state.
REQ-027 Reset mid-op SHALL discard in-flight op; later unit RDY SHALL NOT produce data_resultRDY.
REQ-028 Issue pulse in same cycle as reset SHALL be ignored.

Verification
REQ-029 ctrl_MULT, A=7, B=-3, rd_in=5 -> one START cycle with unit_ctrl_MULT=1; on mult RDY, DONE: data_result=0xFFFFFFEB, data_exception=0, rd_out=5, stall low in DONE.
REQ-030 ctrl_DIV, A=100, B=7 -> unit_ctrl_DIV pulse only; stray mult_resultRDY in WAIT ignored; on div RDY, data_result=14.
REQ-031 ctrl_MULT and ctrl_DIV together, A=3, B=4 -> only unit_ctrl_MULT pulses; result 12.
REQ-032 ctrl_MULT, RDY never asserted, TIMEOUT=40 -> DONE 41 cycles after START, data_exception=1, data_result=0.
REQ-033 reset asserted 3 cycles into WAIT, then unit RDY -> outputs 0, state IDLE, no data_resultRDY pulse.
REQ-034 Second ctrl_MULT issued in DONE of first -> next cycle START, no IDLE cycle; both results reported in order with correct rd_out.
